// File: rtl/npc_redirect_ctrl_if.sv
// rtl/npc_redirect_ctrl_if.sv - EX branch-judge to next-PC redirect interface
interface npc_redirect_ctrl_if;
    logic [1:0]  npc_sel;
    logic        flush_req;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;

    modport master (
        output npc_sel, flush_req, ex_valid, ex_pc, ex_imm, ex_rs1
    );

    modport slave (
        input npc_sel, flush_req, ex_valid, ex_pc, ex_imm, ex_rs1
    );
endinterface

// File: rtl/npc_redirect_ctrl.sv
// rtl/npc_redirect_ctrl.sv - next-PC redirect, PC register and pipeline flush control
// Optional BRANCH_STAT_EN adds saturating redirect/stall statistics counters.
module npc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0004
) (
    input  logic                      clk,
    input  logic                      rst,
    npc_redirect_ctrl_if.slave        bj,
    input  logic                      stall,
    output logic [31:0]               pc,
    output logic                      fetch_valid,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      misalign_err
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0]               stat_redirect_cnt,
    output logic [31:0]               stat_stall_cnt
`endif
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] base;
    logic [31:0] sum;
    logic [31:0] target;
    logic        is_jalr;
    logic        redirect;
    logic        misaligned;
    logic        unused_flush_hint;

    // The select is authoritative; flush_req is only a hint from the judge.
    assign unused_flush_hint = bj.flush_req;
    assign redirect          = bj.ex_valid && (bj.npc_sel != 2'b00);

    assign is_jalr    = (bj.npc_sel == 2'b11);
    assign base       = is_jalr ? bj.ex_rs1 : bj.ex_pc;
    assign sum        = base + bj.ex_imm;
    assign target     = is_jalr ? {sum[31:1], 1'b0} : sum;
    assign misaligned = target[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        fetch_valid  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        misalign_err = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                if (redirect) begin
                    // Both wrong-path instructions are squashed at the same edge.
                    fetch_valid  = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    misalign_err = misaligned;
                    pc_nxt       = misaligned ? TRAP_PC : target;
                end else if (stall) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

`ifdef BRANCH_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_redirect_cnt <= 32'd0;
            stat_stall_cnt    <= 32'd0;
        end else if (state == RUN) begin
            if (redirect) begin
                if (stat_redirect_cnt != 32'hFFFF_FFFF)
                    stat_redirect_cnt <= stat_redirect_cnt + 32'd1;
            end else if (stall) begin
                if (stat_stall_cnt != 32'hFFFF_FFFF)
                    stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_redirect_ctrl.sv
// tb/tb_npc_redirect_ctrl.sv - directed self-checking bench for npc_redirect_ctrl
module tb_npc_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        misalign_err;
`ifdef BRANCH_STAT_EN
    logic [31:0] stat_redirect_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    npc_redirect_ctrl_if bj ();

    npc_redirect_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bj           (bj),
        .stall        (stall),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .misalign_err (misalign_err)
`ifdef BRANCH_STAT_EN
        ,
        .stat_redirect_cnt (stat_redirect_cnt),
        .stat_stall_cnt    (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bj.npc_sel   = 2'b00;
        bj.flush_req = 1'b0;
        bj.ex_valid  = 1'b0;
        bj.ex_pc     = 32'd0;
        bj.ex_imm    = 32'd0;
        bj.ex_rs1    = 32'd0;
        stall        = 1'b0;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] epc,
                         input logic [31:0] imm, input logic [31:0] rs1);
        bj.npc_sel   = sel;
        bj.flush_req = (sel != 2'b00);
        bj.ex_valid  = 1'b1;
        bj.ex_pc     = epc;
        bj.ex_imm    = imm;
        bj.ex_rs1    = rs1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        check("rst_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // BOOT cycle then sequential fetch
        rst = 1'b0;
        #1;
        check("boot_pc", pc, 32'h0);
        check("boot_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("boot_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        step();
        check("run_pc0", pc, 32'h0);
        check("run_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("run_if_id_flush", {31'd0, if_id_flush}, 32'd0);
        check("run_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
        step();
        check("run_pc4", pc, 32'h4);
        step();
        check("run_pc8", pc, 32'h8);
        step();
        check("run_pcC", pc, 32'hC);

        // Taken branch backwards
        drive(2'b01, 32'h100, 32'hFFFF_FFF0, 32'h0);
        #1;
        check("br_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        check("br_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        check("br_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("br_misalign", {31'd0, misalign_err}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("br_pc", pc, 32'h0F0);
        check("br_after_fetch_valid", {31'd0, fetch_valid}, 32'd1);

        // jalr clears bit0
        drive(2'b11, 32'h500, 32'h0, 32'h2001);
        #1;
        check("jalr_misalign", {31'd0, misalign_err}, 32'd0);
        step();
        idle_inputs();
        check("jalr_pc", pc, 32'h2000);

        // jal to misaligned target traps
        drive(2'b10, 32'h40, 32'h6, 32'h0);
        #1;
        check("jal_mis_pulse", {31'd0, misalign_err}, 32'd1);
        step();
        idle_inputs();
        #1;
        check("jal_mis_pc", pc, 32'h4);
        check("jal_mis_clear", {31'd0, misalign_err}, 32'd0);

        // Move to 0x20 then stall for two cycles
        drive(2'b10, 32'h10, 32'h10, 32'h0);
        step();
        idle_inputs();
        stall = 1'b1;
        #1;
        check("stall_pc_a", pc, 32'h20);
        check("stall_if_id", {31'd0, if_id_flush}, 32'd0);
        check("stall_id_ex", {31'd0, id_ex_flush}, 32'd1);
        check("stall_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        step();
        check("stall_pc_b", pc, 32'h20);
        step();
        check("stall_pc_c", pc, 32'h20);

        // Redirect concurrent with stall wins
        drive(2'b01, 32'h20, 32'h60, 32'h0);
        #1;
        check("stall_br_if_id", {31'd0, if_id_flush}, 32'd1);
        check("stall_br_id_ex", {31'd0, id_ex_flush}, 32'd1);
        step();
        idle_inputs();
        check("stall_br_pc", pc, 32'h80);

        // select without flush_req still redirects
        drive(2'b10, 32'h80, 32'h100, 32'h0);
        bj.flush_req = 1'b0;
        #1;
        check("proto_if_id", {31'd0, if_id_flush}, 32'd1);
        step();
        idle_inputs();
        check("proto_pc", pc, 32'h180);

        // Invalid EX ignores select
        drive(2'b01, 32'h0, 32'h400, 32'h0);
        bj.ex_valid = 1'b0;
        #1;
        check("inv_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        step();
        idle_inputs();
        check("inv_pc", pc, 32'h184);

        // Back-to-back redirects then pc+4 wrap
        drive(2'b01, 32'h1000, 32'h10, 32'h0);
        step();
        drive(2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC);
        #1;
        check("b2b_pc", pc, 32'h1010);
        step();
        idle_inputs();
        check("wrap_pc_top", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc_zero", pc, 32'h0);
        step();
        check("wrap_pc_four", pc, 32'h4);

        // Reset mid-redirect discards the target
        drive(2'b01, 32'h500, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        idle_inputs();
        step();
        check("rst_hold_pc", pc, 32'h0);

`ifdef BRANCH_STAT_EN
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 32'h200, 32'h10, 32'h0);
            step();
        end
        idle_inputs();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        #1;
        check("stat_redirect", stat_redirect_cnt, 32'd3);
        check("stat_stall", stat_stall_cnt, 32'd2);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("stat_rst_redirect", stat_redirect_cnt, 32'd0);
        check("stat_rst_stall", stat_stall_cnt, 32'd0);
        check("stat_rst_pc", pc, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
